// File: rtl/serial_sub16_pkg.sv
// serial_sub16_pkg
//   Shared constants and types for the slice-serial 16-bit subtractor.
//   WIDTH : operand/result width (a multiple of SLICE)
//   SLICE : bits resolved per clock
//   STEPS : clock cycles per subtraction
//   IDX_W : width of the slice index counter
package serial_sub16_pkg;

  localparam int WIDTH = 16;
  localparam int SLICE = 4;
  localparam int STEPS = WIDTH / SLICE;
  localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub16_slice.sv
// serial_sub16_slice
//   Combinational W-bit ripple-carry slice: o_s = i_a + i_b_inv + i_cin.
//   The caller supplies the already-inverted subtrahend, so with i_cin=1
//   on the first slice the chain computes a - b.
//   Ports: i_a, i_b_inv (W bits), i_cin -> o_s (W bits), o_cout.
module serial_sub16_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b_inv,
  input  logic         i_cin,
  output logic [W-1:0] o_s,
  output logic         o_cout
);

  logic [W:0] w_c;

  // Bit-by-bit ripple: sum and carry for each position of the slice.
  always_comb begin
    w_c      = '0;
    o_s      = '0;
    w_c[0]   = i_cin;
    for (int i = 0; i < W; i++) begin
      o_s[i]   = i_a[i] ^ i_b_inv[i] ^ w_c[i];
      w_c[i+1] = (i_a[i] & i_b_inv[i]) | (w_c[i] & (i_a[i] ^ i_b_inv[i]));
    end
    o_cout = w_c[W];
  end

endmodule

// File: rtl/serial_sub16.sv
// serial_sub16
//   Multi-cycle two's-complement subtractor, diff = a + ~b + 1, resolved one
//   SLICE-bit slice per clock through a single shared slice adder.
//   Ports:
//     i_clk, i_rst_n        clock (rising edge), async active-low reset
//     i_start               request, taken only in IDLE or DONE
//     i_a, i_b              operands, latched on the accepting edge
//     o_busy                high while the slices are being processed
//     o_done                one-cycle pulse, results valid
//     o_diff                a - b mod 2^WIDTH
//     o_overflow            signed overflow of a - b
//     o_borrow              unsigned borrow (a < b)
//   Results only change on completion and hold through the next operation.
//   rst_n is expected to be released synchronously by the reset tree.
module serial_sub16
  import serial_sub16_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_overflow,
  output logic             o_borrow
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b_inv;
  logic [WIDTH-1:0]  r_work;
  logic              r_carry;
  logic [IDX_W-1:0]  r_idx;

  logic              w_accept;
  logic              w_last;
  logic [SLICE-1:0]  w_s;
  logic              w_cout;
  logic [WIDTH-1:0]  w_work_nxt;

  // One shared slice adder; the operand slices are selected by r_idx.
  serial_sub16_slice #(.W(SLICE)) u_slice (
    .i_a     (r_a[r_idx*SLICE +: SLICE]),
    .i_b_inv (r_b_inv[r_idx*SLICE +: SLICE]),
    .i_cin   (r_carry),
    .o_s     (w_s),
    .o_cout  (w_cout)
  );

  // Work register with the current slice result merged in.
  always_comb begin
    w_work_nxt = r_work;
    w_work_nxt[r_idx*SLICE +: SLICE] = w_s;
  end

  // Next-state logic and the accept / last-slice strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_idx == IDX_W'(STEPS - 1)) begin
          w_state_nxt = ST_DONE;
          w_last      = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        // Back-to-back: a start here goes straight into RUN.
        if (i_start) begin
          w_state_nxt = ST_RUN;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register plus registered busy/done decoded from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      o_busy  <= (w_state_nxt == ST_RUN);
      o_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Operand latch and slice-serial datapath (borrow chain held in r_carry).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b_inv <= '0;
      r_work  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b_inv <= ~i_b;
      r_carry <= 1'b1;
      r_idx   <= '0;
    end else if (r_state == ST_RUN) begin
      r_work  <= w_work_nxt;
      r_carry <= w_cout;
      r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
    end
  end

  // Result registers: only written on the last slice, so partial sums never show.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_diff     <= '0;
      o_overflow <= 1'b0;
      o_borrow   <= 1'b0;
    end else if (w_last) begin
      o_diff     <= w_work_nxt;
      o_borrow   <= ~w_cout;
      // Signs of a and b differ and the result sign departs from a.
      o_overflow <= (r_a[WIDTH-1] != ~r_b_inv[WIDTH-1]) &&
                    (w_work_nxt[WIDTH-1] != r_a[WIDTH-1]);
    end
  end

endmodule
